praxos_boot_seq: RTL

Hardware sequencer that boots the Praxos core: holds it in reset, streams a program image into Praxos program memory over a valid/ready input, then optionally releases reset.
Sits between a DMA/stream source (or the CPU-side control logic) and the Praxos PM write port plus the Praxos reset input.
Replaces word-by-word software loading through the control register file.
Reports completion and errors with a sticky status and a one-cycle interrupt pulse.

---
 rtl/praxos_boot_pkg.sv | 21 ++
 rtl/praxos_boot_seq.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/praxos_boot_pkg.sv
// Shared types and constants for the Praxos boot sequencer and the Praxos control logic.
// No logic of its own; default PM geometry matches the Praxos program memory.
package praxos_boot_pkg;

    localparam int PRAXOS_PM_AW = 8;
    localparam int PRAXOS_PM_DW = 36;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_LOAD   = 3'd2,
        ST_SETTLE = 3'd3,
        ST_RUN    = 3'd4
    } boot_state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [1:0] ERR_ABORT   = 2'd3;

endpackage

// File: rtl/praxos_boot_seq.sv
// Boots Praxos: holds its reset, streams an image into PM, optionally releases reset.
// PM write lands one cycle after each accepted beat; s_ready is high only in LOAD, so the source stalls elsewhere.
module praxos_boot_seq
    import praxos_boot_pkg::*;
#(
    parameter int PM_AW    = PRAXOS_PM_AW,
    parameter int PM_DW    = PRAXOS_PM_DW,
    parameter int RST_HOLD = 4,
    parameter int SETTLE   = 2,
    parameter int TIMEOUT  = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [PM_AW-1:0] base_addr,
    input  logic [PM_AW:0]   word_cnt,
    input  logic             run_after_load,
    input  logic [PM_DW-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic             praxos_rst_n,
    output logic [PM_AW-1:0] praxos_pm_wr_addr,
    output logic             praxos_pm_wr,
    output logic [PM_DW-1:0] praxos_pm_wr_data,
    output logic             busy,
    output logic             done,
    output logic [1:0]       err,
    output logic             irq
);

    localparam int TMR_MAX = (RST_HOLD > SETTLE) ? RST_HOLD : SETTLE;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    localparam logic [PM_AW+1:0] PM_DEPTH = {2'b01, {PM_AW{1'b0}}};

    boot_state_t       state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [PM_AW:0]     idx_q, idx_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic [PM_AW-1:0]   base_q, base_d;
    logic [PM_AW:0]     cnt_q, cnt_d;
    logic               run_q, run_d;
    logic               prst_n_q, prst_n_d;
    logic               pm_wr_q, pm_wr_d;
    logic [PM_AW-1:0]   pm_wr_addr_q, pm_wr_addr_d;
    logic [PM_DW-1:0]   pm_wr_data_q, pm_wr_data_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [1:0]         err_q, err_d;
    logic               irq_q, irq_d;

    logic               load_st;
    logic               beat;
    logic               in_seq;
    logic [PM_AW+1:0]   end_addr;

    assign load_st  = (state_q == ST_LOAD);
    assign beat     = s_valid & load_st;
    assign in_seq   = (state_q == ST_HOLD) || (state_q == ST_LOAD) || (state_q == ST_SETTLE);
    assign end_addr = {2'b00, base_addr} + {1'b0, word_cnt};

    always_comb begin
        state_d      = state_q;
        tmr_d        = tmr_q;
        idx_d        = idx_q;
        stall_d      = stall_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        run_d        = run_q;
        prst_n_d     = prst_n_q;
        pm_wr_d      = 1'b0;
        pm_wr_addr_d = pm_wr_addr_q;
        pm_wr_data_d = pm_wr_data_q;
        done_d       = done_q;
        err_d        = err_q;
        irq_d        = 1'b0;

        if (abort && in_seq) begin
            // A write registered last cycle still drives PM; the beat in this cycle is dropped.
            state_d  = ST_IDLE;
            prst_n_d = 1'b0;
            err_d    = ERR_ABORT;
            irq_d    = 1'b1;
        end else begin
            case (state_q)
                ST_IDLE, ST_RUN: begin
                    if (abort) begin
                        if (state_q == ST_RUN) begin
                            state_d  = ST_IDLE;
                            prst_n_d = 1'b0;
                        end
                    end else if (start) begin
                        base_d = base_addr;
                        cnt_d  = word_cnt;
                        run_d  = run_after_load;
                        done_d = 1'b0;
                        err_d  = ERR_NONE;
                        if (end_addr > PM_DEPTH) begin
                            state_d = ST_IDLE;
                            err_d   = ERR_RANGE;
                            irq_d   = 1'b1;
                        end else begin
                            state_d  = ST_HOLD;
                            prst_n_d = 1'b0;
                            tmr_d    = '0;
                        end
                    end
                end
                ST_HOLD: begin
                    if (tmr_q == TMR_W'(RST_HOLD - 1)) begin
                        tmr_d   = '0;
                        idx_d   = '0;
                        stall_d = '0;
                        state_d = (cnt_q == '0) ? ST_SETTLE : ST_LOAD;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        pm_wr_d      = 1'b1;
                        pm_wr_addr_d = base_q + idx_q[PM_AW-1:0];
                        pm_wr_data_d = s_data;
                        idx_d        = idx_q + 1'b1;
                        stall_d      = '0;
                        if (idx_q == cnt_q - 1'b1) begin
                            state_d = ST_SETTLE;
                            tmr_d   = '0;
                        end
                    end else if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                        state_d = ST_IDLE;
                        err_d   = ERR_TIMEOUT;
                        irq_d   = 1'b1;
                        stall_d = '0;
                    end else begin
                        stall_d = stall_q + 1'b1;
                    end
                end
                ST_SETTLE: begin
                    if (tmr_q == TMR_W'(SETTLE - 1)) begin
                        tmr_d    = '0;
                        done_d   = 1'b1;
                        irq_d    = 1'b1;
                        prst_n_d = run_q;
                        state_d  = run_q ? ST_RUN : ST_IDLE;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    prst_n_d = 1'b0;
                end
            endcase
        end

        busy_d = (state_d == ST_HOLD) || (state_d == ST_LOAD) || (state_d == ST_SETTLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            idx_q        <= '0;
            stall_q      <= '0;
            base_q       <= '0;
            cnt_q        <= '0;
            run_q        <= 1'b0;
            prst_n_q     <= 1'b0;
            pm_wr_q      <= 1'b0;
            pm_wr_addr_q <= '0;
            pm_wr_data_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= ERR_NONE;
            irq_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            idx_q        <= idx_d;
            stall_q      <= stall_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            run_q        <= run_d;
            prst_n_q     <= prst_n_d;
            pm_wr_q      <= pm_wr_d;
            pm_wr_addr_q <= pm_wr_addr_d;
            pm_wr_data_q <= pm_wr_data_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            irq_q        <= irq_d;
        end
    end

    assign s_ready           = load_st;
    assign praxos_rst_n      = prst_n_q;
    assign praxos_pm_wr      = pm_wr_q;
    assign praxos_pm_wr_addr = pm_wr_addr_q;
    assign praxos_pm_wr_data = pm_wr_data_q;
    assign busy              = busy_q;
    assign done              = done_q;
    assign err               = err_q;
    assign irq               = irq_q;

endmodule
